// File: rtl/demux1to16_sipo_pkg.sv
// demux1to16_sipo_pkg: shared sizes and output buffer state encoding
package demux1to16_sipo_pkg;
  localparam int MUX_WIDTH = 16;
  localparam int MUX_SEL_W = 4;
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;
endpackage

// File: rtl/demux1to16_sipo_decoder4to16.sv
// decoder4to16: select index to one-hot slot write enables, gated by en
module decoder4to16 #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [0:WIDTH-1] onehot
);
  // exactly one enable raised at the selected slot when en is high
  always_comb begin
    onehot = '0;
    onehot[sel] = en;
  end
endmodule

// File: rtl/demux1to16_sipo.sv
// demux1to16_sipo: steers serial bits into slots and hands off full words via valid/ack
module demux1to16_sipo
  import demux1to16_sipo_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             d_in,
  input  logic             d_valid,
  input  logic             w_ack,
  output logic [0:WIDTH-1] w_out,
  output logic             w_valid,
  output logic [SEL_W-1:0] sel,
  output logic             overrun
);
  buf_state_t       state;
  logic [0:WIDTH-1] collect;
  logic [0:WIDTH-1] collect_next;
  logic [0:WIDTH-1] wr_en;
  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] sel_next;
  logic             complete;

  decoder4to16 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
    .en     (d_valid),
    .sel    (eff_sel),
    .onehot (wr_en)
  );

  // sync restarts the frame at slot 0 and drops the partial word; collect_next doubles as the completed word
  always_comb begin
    eff_sel = sync ? '0 : sel;
    complete = d_valid && (eff_sel == SEL_W'(WIDTH - 1));
    sel_next = d_valid ? eff_sel + SEL_W'(1) : eff_sel;
    collect_next = ((sync ? '0 : collect) & ~wr_en) | ({WIDTH{d_in}} & wr_en);
  end

  assign w_valid = (state == BUF_FULL);

  // counter, collect register, output buffer FSM and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUF_EMPTY;
      sel <= '0;
      collect <= '0;
      w_out <= '0;
      overrun <= 1'b0;
    end else begin
      sel <= sel_next;
      collect <= collect_next;
      if (complete && (state == BUF_EMPTY || w_ack)) begin
        w_out <= collect_next;
        state <= BUF_FULL;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (state == BUF_FULL && w_ack) begin
        state <= BUF_EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_demux1to16_sipo.sv
// tb_demux1to16_sipo: randomized and directed checks against a slot-array reference model
module tb_demux1to16_sipo;
  logic        clk = 0, rst = 0, sync = 0, d_in = 0, d_valid = 0, w_ack = 0;
  logic [0:15] w_out;
  logic        w_valid, overrun;
  logic [3:0]  sel;
  int n_checks = 0, n_fail = 0;
  bit          m_col[16];
  logic [0:15] m_out = '0;
  int          m_sel = 0;
  bit          m_full = 0, m_ovr = 0;

  demux1to16_sipo dut (
    .clk(clk), .rst(rst), .sync(sync), .d_in(d_in), .d_valid(d_valid), .w_ack(w_ack),
    .w_out(w_out), .w_valid(w_valid), .sel(sel), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit s, input bit b, input bit v, input bit a);
    int slot;
    logic [0:15] word;
    rst = r; sync = s; d_in = b; d_valid = v; w_ack = a;
    if (r) begin
      foreach (m_col[k]) m_col[k] = 0;
      m_sel = 0; m_out = '0; m_full = 0; m_ovr = 0;
    end else begin
      slot = s ? 0 : m_sel;
      if (s) foreach (m_col[k]) m_col[k] = 0;
      if (v) m_col[slot] = b;
      if (v && slot == 15) begin
        foreach (m_col[k]) word[k] = m_col[k];
        if (!m_full || a) begin m_out = word; m_full = 1; end
        else m_ovr = 1;
      end else if (m_full && a) m_full = 0;
      m_sel = v ? (slot + 1) % 16 : slot;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [0:15] w, input bit ack_last);
    for (int i = 0; i < 16; i++) step(0, 0, w[i], 1, ack_last && i == 15);
  endtask

  task automatic test_reset;
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 0);
    n_checks++;
    if ({w_out, w_valid, sel, overrun} !== 22'd0) begin
      n_fail++; $display("FAIL reset: got %h/%b/%0d/%b want 0/0/0/0", w_out, w_valid, sel, overrun);
    end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, (i % 2) == 0, 1, 0);
      n_checks++;
      if (sel !== 4'((i + 1) % 16)) begin
        n_fail++; $display("FAIL stream_sel[%0d]: got %0d want %0d", i, sel, (i + 1) % 16);
      end
    end
    n_checks++;
    if (w_out !== 16'hAAAA || w_valid !== 1'b1 || w_out !== m_out) begin
      n_fail++; $display("FAIL stream_word: got %h/%b want aaaa/1", w_out, w_valid);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (w_valid !== 1'b0 || w_out !== 16'hAAAA) begin
      n_fail++; $display("FAIL stream_ack: got %h/%b want aaaa/0", w_out, w_valid);
    end
  endtask

  task automatic test_back_to_back;
    send_word(16'hAAAA, 0);
    send_word(16'h5555, 1);
    n_checks++;
    if (w_out !== 16'h5555 || w_valid !== 1'b1 || overrun !== 1'b0 || w_out !== m_out) begin
      n_fail++; $display("FAIL b2b: got %h/%b/%b want 5555/1/0", w_out, w_valid, overrun);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_overrun;
    send_word(16'h00FF, 0);
    send_word(16'hFF00, 0);
    n_checks++;
    if (w_out !== 16'h00FF || w_valid !== 1'b1 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun: got %h/%b/%b want 00ff/1/1", w_out, w_valid, overrun);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (w_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_ack: got %b/%b want 0/1", w_valid, overrun);
    end
  endtask

  task automatic test_resync;
    for (int i = 0; i < 5; i++) step(0, 0, 1'($urandom), 1, 0);
    step(0, 1, 1, 1, 0);
    n_checks++;
    if (sel !== 4'd1) begin
      n_fail++; $display("FAIL resync_sel: got %0d want 1", sel);
    end
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0);
    n_checks++;
    if (w_out !== 16'h8000 || sel !== 4'd0 || w_valid !== 1'b1) begin
      n_fail++; $display("FAIL resync: got %h/%0d/%b want 8000/0/1", w_out, sel, w_valid);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (sel !== 4'd0 || overrun !== 1'b0 || w_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: got %0d/%b/%b want 0/0/0", sel, overrun, w_valid);
    end
    send_word(16'h1234, 0);
    n_checks++;
    if (w_out !== 16'h1234 || overrun !== 1'b0 || w_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst: got %h/%b/%b want 1234/0/1", w_out, overrun, w_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      n_checks++;
      if ({w_out, w_valid, sel, overrun} !== {m_out, m_full, 4'(m_sel), m_ovr}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                 w_out, w_valid, sel, overrun, m_out, m_full, m_sel, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_back_to_back;
    test_overrun;
    test_resync;
    test_mid_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
